// File: rtl/bp_me_mem_fwd_arbiter_pkg.sv
// Shared helpers for the BedRock memory forward arbiter: counter sizing and lce_id extraction.
package bp_me_mem_fwd_arbiter_pkg;

    localparam int unsigned MaxHdrW = 512;

    function automatic int unsigned ctr_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [31:0] lce_id_field(input logic [MaxHdrW-1:0] hdr,
                                                 input int unsigned offset,
                                                 input int unsigned width);
        logic [MaxHdrW-1:0] shifted;
        logic [31:0]        mask;
        shifted = hdr >> offset;
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/bp_me_rr_lock_arb.sv
// Round-robin arbiter that holds its grant across a multi-beat message and
// advances its pointer past the winner once the last beat is accepted.
module bp_me_rr_lock_arb #(
    parameter int unsigned NumReq = 3,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NumReq-1:0] i_eligible,
    input  logic            i_handshake,
    input  logic            i_last,
    output logic [IdxW-1:0] o_grant,
    output logic            o_grant_v
);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] r_idx;
    logic            r_lock;
    logic [IdxW-1:0] w_pick;
    logic            w_found;

    always_comb begin
        w_pick  = r_ptr;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            int unsigned p;
            p = 32'(r_ptr) + k;
            if (p >= NumReq) p = p - NumReq;
            if (!w_found && i_eligible[p[IdxW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = p[IdxW-1:0];
            end
        end
    end

    // While locked the held index wins regardless of eligibility.
    assign o_grant   = r_lock ? r_idx : w_pick;
    assign o_grant_v = r_lock | w_found;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr  <= '0;
            r_idx  <= '0;
            r_lock <= 1'b0;
        end else if (i_handshake) begin
            if (i_last) begin
                r_lock <= 1'b0;
                r_ptr  <= (o_grant == IdxW'(NumReq - 1)) ? '0 : o_grant + 1'b1;
            end else begin
                r_lock <= 1'b1;
                r_idx  <= o_grant;
            end
        end
    end

endmodule

// File: rtl/bp_me_mem_fwd_arbiter.sv
// Shares one BedRock memory stream port among several requesters: round-robin forward
// arbitration, lce_id-routed reverse path and per-requester outstanding-message credits.
module bp_me_mem_fwd_arbiter
    import bp_me_mem_fwd_arbiter_pkg::*;
#(
    parameter int unsigned num_req_p         = 3,
    parameter int unsigned header_width_p    = 64,
    parameter int unsigned data_width_p      = 64,
    parameter int unsigned lce_id_width_p    = 4,
    parameter int unsigned lce_id_offset_p   = 0,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p*lce_id_width_p-1:0] lce_id_i,
    input  logic [num_req_p*header_width_p-1:0] req_fwd_header_i,
    input  logic [num_req_p*data_width_p-1:0]   req_fwd_data_i,
    input  logic [num_req_p-1:0]                req_fwd_last_i,
    input  logic [num_req_p-1:0]                req_fwd_v_i,
    output logic [num_req_p-1:0]                req_fwd_ready_and_o,
    output logic [num_req_p*header_width_p-1:0] req_rev_header_o,
    output logic [num_req_p*data_width_p-1:0]   req_rev_data_o,
    output logic [num_req_p-1:0]                req_rev_v_o,
    input  logic [num_req_p-1:0]                req_rev_ready_and_i,
    output logic [num_req_p-1:0]                credits_full_o,
    output logic [num_req_p-1:0]                credits_empty_o,
    output logic [header_width_p-1:0]           mem_fwd_header_o,
    output logic [data_width_p-1:0]             mem_fwd_data_o,
    output logic                                mem_fwd_last_o,
    output logic                                mem_fwd_v_o,
    input  logic                                mem_fwd_ready_and_i,
    input  logic [header_width_p-1:0]           mem_rev_header_i,
    input  logic [data_width_p-1:0]             mem_rev_data_i,
    input  logic                                mem_rev_last_i,
    input  logic                                mem_rev_v_i,
    output logic                                mem_rev_ready_and_o,
    output logic                                rev_err_o
);

    localparam int unsigned CntW = ctr_width(max_outstanding_p);
    localparam int unsigned IdxW = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [header_width_p-1:0] w_fwd_hdr  [num_req_p];
    logic [data_width_p-1:0]   w_fwd_data [num_req_p];
    logic [lce_id_width_p-1:0] w_lce_id   [num_req_p];
    logic [CntW-1:0]           r_cnt      [num_req_p];
    logic [num_req_p-1:0]      w_elig;
    logic [num_req_p-1:0]      w_inc;
    logic [num_req_p-1:0]      w_dec;

    logic [IdxW-1:0] w_grant;
    logic            w_grant_v;
    logic            w_fwd_hs;

    logic [lce_id_width_p-1:0] w_rev_lce;
    logic [IdxW-1:0]           w_match;
    logic                      w_match_v;
    logic [IdxW-1:0]           w_rev_tgt;
    logic                      w_rev_hit;
    logic                      w_rev_hs;
    logic                      r_rev_lock;
    logic                      r_rev_hit;
    logic [IdxW-1:0]           r_rev_idx;
    logic                      r_rev_err;

    for (genvar i = 0; i < num_req_p; i++) begin : g_port
        assign w_fwd_hdr[i]  = req_fwd_header_i[i*header_width_p +: header_width_p];
        assign w_fwd_data[i] = req_fwd_data_i[i*data_width_p +: data_width_p];
        assign w_lce_id[i]   = lce_id_i[i*lce_id_width_p +: lce_id_width_p];
        assign w_elig[i]     = req_fwd_v_i[i] && (r_cnt[i] < CntW'(max_outstanding_p));

        assign w_inc[i] = w_fwd_hs & mem_fwd_last_o & (w_grant == IdxW'(i));
        assign w_dec[i] = w_rev_hs & mem_rev_last_i & w_rev_hit & (w_rev_tgt == IdxW'(i));

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end

        assign credits_full_o[i]  = (r_cnt[i] == CntW'(max_outstanding_p));
        assign credits_empty_o[i] = (r_cnt[i] == '0);

        // A response for a requester with nothing outstanding is a protocol error.
        assert property (@(posedge clk_i) disable iff (reset_i)
                         !(w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)));
    end

    bp_me_rr_lock_arb #(
        .NumReq (num_req_p),
        .IdxW   (IdxW)
    ) u_fwd_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_eligible  (w_elig),
        .i_handshake (w_fwd_hs),
        .i_last      (mem_fwd_last_o),
        .o_grant     (w_grant),
        .o_grant_v   (w_grant_v)
    );

    assign mem_fwd_header_o = w_fwd_hdr[w_grant];
    assign mem_fwd_data_o   = w_fwd_data[w_grant];
    assign mem_fwd_last_o   = req_fwd_last_i[w_grant];
    assign mem_fwd_v_o      = w_grant_v & req_fwd_v_i[w_grant];
    assign w_fwd_hs         = mem_fwd_v_o & mem_fwd_ready_and_i;

    always_comb begin
        req_fwd_ready_and_o = '0;
        if (w_grant_v) req_fwd_ready_and_o[w_grant] = mem_fwd_ready_and_i;
    end

    assign w_rev_lce = lce_id_width_p'(lce_id_field(MaxHdrW'(mem_rev_header_i),
                                                    lce_id_offset_p, lce_id_width_p));

    // Lowest index wins when several ports share an lce_id.
    always_comb begin
        w_match_v = 1'b0;
        w_match   = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (!w_match_v && (w_lce_id[i] == w_rev_lce)) begin
                w_match_v = 1'b1;
                w_match   = IdxW'(i);
            end
        end
    end

    assign w_rev_tgt = r_rev_lock ? r_rev_idx : w_match;
    assign w_rev_hit = r_rev_lock ? r_rev_hit : w_match_v;

    always_comb begin
        req_rev_v_o = '0;
        if (w_rev_hit) req_rev_v_o[w_rev_tgt] = mem_rev_v_i;
    end

    assign req_rev_header_o    = {num_req_p{mem_rev_header_i}};
    assign req_rev_data_o      = {num_req_p{mem_rev_data_i}};
    assign mem_rev_ready_and_o = w_rev_hit ? req_rev_ready_and_i[w_rev_tgt] : 1'b1;
    assign w_rev_hs            = mem_rev_v_i & mem_rev_ready_and_o;
    assign rev_err_o           = r_rev_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rev_lock <= 1'b0;
            r_rev_hit  <= 1'b0;
            r_rev_idx  <= '0;
            r_rev_err  <= 1'b0;
        end else if (w_rev_hs) begin
            r_rev_lock <= !mem_rev_last_i;
            r_rev_hit  <= w_rev_hit;
            r_rev_idx  <= w_rev_tgt;
            if (!w_rev_hit) r_rev_err <= 1'b1;
        end
    end

endmodule
